skew_count_checker: RTL and testbench
=====================================

# skew_count_checker

Receive-side monitor for the skewed-phase counter. It consumes the four phase strobes and the 16-bit count with terminal-count flag, and checks three properties on every clock: the phases rotate correctly, the count increments by one per phase rotation, and TC agrees with the count. It reports lock status, per-class sticky error flags, a saturating error count and a wrap count. It sits beside the counter in the top level and is used both on the bench and on hardware for self-check.

## Interface
- ACQ_GOOD, default 4: number of consecutive good samples required to enter LOCKED (range 1..15).
- ERR_W, default 8: width of the error and wrap counters.
- clk  in  1  single system clock; all inputs are synchronous to it.
- reset  in  1  synchronous, active-high reset.
- en  in  1  checking enable; low forces IDLE.
- clr_err  in  1  one-cycle pulse; clears sticky flags and err_cnt.
- sQ0, sQ1, sQ2, sQ3  in  1 each  phase strobes from the skewed clock generator.
- Q  in  16  count under check.
- TC  in  1  terminal-count flag under check.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse on any detected error.
- err_phase, err_seq, err_tc  out  1 each  sticky error flags, one per error class.
- err_cnt  out  ERR_W  saturating count of error events.
- wraps  out  ERR_W  saturating count of accepted samples with Q = 16'hFFFF.

## Operation
- Phase vector P = {sQ3, sQ2, sQ1, sQ0}.
  - Legal P is one-hot.
  - Legal successor of the previous P is that P rotated left (bit3 wraps to bit0).
- Phase check, applied every cycle in ACQUIRE and LOCKED:
  - Error if P is not one-hot.
  - Error if the previous P was valid and P is not its rotation.
  - Class: phase.
- Sample strobe is sQ3 high with P legal. Q and TC are sampled only on a strobe.
- Sequence check, on a strobe with a held reference R:
  - Error if Q != R + 1 (mod 2^16). Class: seq.
  - R is then loaded with Q, whether or not the check passed.
- TC check, on every strobe: error if TC != (Q == 16'hFFFF). Class: tc.
- State machine:
  - IDLE: outputs quiescent, no reference held, good-count G = 0. Goes to ACQUIRE when en = 1.
  - ACQUIRE: the first strobe loads R and is not checked for seq. Each later error-free strobe increments G. Any error clears G and stays in ACQUIRE. When G reaches ACQ_GOOD, go to LOCKED.
  - LOCKED: any error goes to ACQUIRE with G = 0 and R kept (the sample that caused the error reloads R).
  - en = 0 in any state goes to IDLE next cycle and drops the reference.
- Error event handling:
  - An error event is any cycle with at least one class error.
  - err_pulse fires once per event.
  - err_cnt increments by 1 per event, even if several classes fire in the same cycle.
  - Every class that fired sets its sticky flag.
- Error reporting is active in ACQUIRE and LOCKED, except for seq errors in ACQUIRE before R is loaded.
- wraps increments on accepted strobes (no error) with Q = 16'hFFFF, in any non-IDLE state.
- Both counters saturate at all-ones.
- clr_err clears the sticky flags and err_cnt. It does not clear wraps or the state.
  - If clr_err coincides with an error event, the new event wins: flags = the classes of that event, err_cnt = 1.

## Timing
- Reset values: locked = 0, err_pulse = 0, all sticky flags = 0, err_cnt = 0, wraps = 0, state = IDLE, R invalid, G = 0, previous P invalid.
- Inputs are evaluated combinationally in cycle N. All outputs are registered and reflect cycle N at cycle N+1.
- locked rises in the cycle after the ACQ_GOOD-th good strobe. It falls in the cycle after the offending input.
- Reset asserted mid-operation returns everything to the reset values on the next edge, regardless of en.
- After reset or IDLE, the first cycle's P is not rotation-checked (only the one-hot check applies).
- Seq check across wrap: R = 16'hFFFF followed by Q = 16'h0000 is legal.

## Test plan
- Clean run, ACQ_GOOD = 4: phases rotate 0→3 and Q steps 0,1,2,… on each sQ3 → locked rises 1 cycle after the 5th strobe (1 reference load + 4 good); no errors.
- Wrap: Q steps FFFE, FFFF, 0000 with TC = 1 only at FFFF → wraps = 1, no errors, locked stays 1.
- Skip: while locked, Q jumps 0x0010 → 0x0012 → err_pulse once, err_seq = 1, err_cnt = 1, locked drops, then relocks after 4 further good strobes.
- Bad phase: P = 4'b0011 for one cycle while locked → err_phase = 1, err_cnt = 1, locked = 0. Same cycle also carrying a TC mismatch on sQ3 → still err_cnt = 1 with only err_phase set (the strobe is not accepted).
- TC mismatch: TC = 1 at Q = 0x1234 → err_tc = 1. Then clr_err pulse → flags = 0, err_cnt = 0, wraps unchanged.
- Reset and en: assert reset mid-LOCKED → all outputs 0 next cycle. With en = 0, apply garbage phases → no errors, state IDLE.

Source files
------------

// File: rtl/skew_count_checker.sv
// skew_count_checker: receive-side monitor for the skewed-phase counter.
// Checks phase rotation, count sequence and TC agreement on every clock,
// tracks lock status, and keeps sticky error flags plus saturating
// error and wrap counters.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | checking disabled, no reference held, outputs quiescent
//   ST_ACQUIRE | checking; counting consecutive good strobes toward lock
//   ST_LOCKED  | checking; any error drops back to ST_ACQUIRE
module skew_count_checker #(
    parameter int ACQ_GOOD = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr_err,
    input  logic             sQ0,
    input  logic             sQ1,
    input  logic             sQ2,
    input  logic             sQ3,
    input  logic [15:0]      Q,
    input  logic             TC,
    output logic             locked,
    output logic             err_pulse,
    output logic             err_phase,
    output logic             err_seq,
    output logic             err_tc,
    output logic [ERR_W-1:0] err_cnt,
    output logic [ERR_W-1:0] wraps
);

    typedef enum logic [1:0] {ST_IDLE, ST_ACQUIRE, ST_LOCKED} state_t;

    localparam logic [ERR_W-1:0] CNT_MAX  = '1;
    localparam logic [3:0]       GOOD_TGT = 4'(ACQ_GOOD);

    state_t           state_q, state_d;
    logic [15:0]      ref_q, ref_d;
    logic             ref_vld_q, ref_vld_d;
    logic [3:0]       prev_p_q, prev_p_d;
    logic             prev_vld_q, prev_vld_d;
    logic [3:0]       good_q, good_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic             err_phase_q, err_phase_d;
    logic             err_seq_q, err_seq_d;
    logic             err_tc_q, err_tc_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [ERR_W-1:0] wraps_q, wraps_d;

    logic [3:0] p;
    logic       active;
    logic       p_onehot;
    logic       p_rot_ok;
    logic       strobe;
    logic       e_phase;
    logic       e_seq;
    logic       e_tc;
    logic       any_err;

    // Per-cycle error classification; a strobe is only taken on a legal phase.
    always_comb begin
        p        = {sQ3, sQ2, sQ1, sQ0};
        active   = en && (state_q != ST_IDLE);
        p_onehot = $onehot(p);
        p_rot_ok = !prev_vld_q || (p == {prev_p_q[2:0], prev_p_q[3]});
        e_phase  = active && !(p_onehot && p_rot_ok);
        strobe   = active && sQ3 && !e_phase;
        e_seq    = strobe && ref_vld_q && (Q != ref_q + 16'd1);
        e_tc     = strobe && (TC != (Q == 16'hFFFF));
        any_err  = e_phase || e_seq || e_tc;
    end

    // Lock state machine, reference tracking and error/wrap bookkeeping.
    always_comb begin
        state_d     = state_q;
        ref_d       = ref_q;
        ref_vld_d   = ref_vld_q;
        prev_p_d    = prev_p_q;
        prev_vld_d  = prev_vld_q;
        good_d      = good_q;
        err_phase_d = err_phase_q;
        err_seq_d   = err_seq_q;
        err_tc_d    = err_tc_q;
        err_cnt_d   = err_cnt_q;
        wraps_d     = wraps_q;

        if (!en) begin
            state_d    = ST_IDLE;
            ref_vld_d  = 1'b0;
            prev_vld_d = 1'b0;
            good_d     = 4'd0;
        end else if (state_q == ST_IDLE) begin
            state_d    = ST_ACQUIRE;
            good_d     = 4'd0;
        end else begin
            prev_p_d   = p;
            prev_vld_d = p_onehot;
            if (strobe) begin
                ref_d     = Q;
                ref_vld_d = 1'b1;
            end
            if (any_err) begin
                state_d = ST_ACQUIRE;
                good_d  = 4'd0;
            end else if (strobe && ref_vld_q && (state_q == ST_ACQUIRE)) begin
                good_d = good_q + 4'd1;
                if (good_d == GOOD_TGT) begin
                    state_d = ST_LOCKED;
                    good_d  = 4'd0;
                end
            end
        end

        // A new event beats a coincident clear: flags restart from this event.
        if (any_err) begin
            if (clr_err) begin
                err_phase_d = e_phase;
                err_seq_d   = e_seq;
                err_tc_d    = e_tc;
                err_cnt_d   = {{(ERR_W-1){1'b0}}, 1'b1};
            end else begin
                err_phase_d = err_phase_q || e_phase;
                err_seq_d   = err_seq_q || e_seq;
                err_tc_d    = err_tc_q || e_tc;
                if (err_cnt_q != CNT_MAX) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
            end
        end else if (clr_err) begin
            err_phase_d = 1'b0;
            err_seq_d   = 1'b0;
            err_tc_d    = 1'b0;
            err_cnt_d   = '0;
        end

        if (strobe && !any_err && (Q == 16'hFFFF) && (wraps_q != CNT_MAX)) begin
            wraps_d = wraps_q + 1'b1;
        end

        locked_d    = (state_d == ST_LOCKED);
        err_pulse_d = any_err;
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ref_q       <= 16'd0;
            ref_vld_q   <= 1'b0;
            prev_p_q    <= 4'd0;
            prev_vld_q  <= 1'b0;
            good_q      <= 4'd0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_phase_q <= 1'b0;
            err_seq_q   <= 1'b0;
            err_tc_q    <= 1'b0;
            err_cnt_q   <= '0;
            wraps_q     <= '0;
        end else begin
            state_q     <= state_d;
            ref_q       <= ref_d;
            ref_vld_q   <= ref_vld_d;
            prev_p_q    <= prev_p_d;
            prev_vld_q  <= prev_vld_d;
            good_q      <= good_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_phase_q <= err_phase_d;
            err_seq_q   <= err_seq_d;
            err_tc_q    <= err_tc_d;
            err_cnt_q   <= err_cnt_d;
            wraps_q     <= wraps_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_phase = err_phase_q;
    assign err_seq   = err_seq_q;
    assign err_tc    = err_tc_q;
    assign err_cnt   = err_cnt_q;
    assign wraps     = wraps_q;

endmodule

// File: tb/tb_skew_count_checker.sv
// Bench for skew_count_checker: directed scenarios followed by randomized
// fault injection, every cycle compared against a behavioural model.
module tb_skew_count_checker;

    localparam int ACQ_GOOD = 4;
    localparam int ERR_W    = 8;
    localparam int CMAX     = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             reset, en, clr_err;
    logic             sQ0, sQ1, sQ2, sQ3;
    logic [15:0]      Q;
    logic             TC;
    logic             locked, err_pulse, err_phase, err_seq, err_tc;
    logic [ERR_W-1:0] err_cnt, wraps;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model: mode 0 = idle, 1 = acquiring, 2 = locked
    int          m_mode, m_good, m_ecnt, m_wraps;
    bit          m_ref_ok, m_prev_ok;
    int          m_ref;
    logic [3:0]  m_prev;
    bit          m_locked, m_pulse, m_fp, m_fs, m_ft;

    // stimulus generator: phase index and the next count to present
    int          k;
    logic [15:0] cnt;

    skew_count_checker #(.ACQ_GOOD(ACQ_GOOD), .ERR_W(ERR_W)) dut (
        .clk(clk), .reset(reset), .en(en), .clr_err(clr_err),
        .sQ0(sQ0), .sQ1(sQ1), .sQ2(sQ2), .sQ3(sQ3), .Q(Q), .TC(TC),
        .locked(locked), .err_pulse(err_pulse), .err_phase(err_phase),
        .err_seq(err_seq), .err_tc(err_tc), .err_cnt(err_cnt), .wraps(wraps)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_good = 0; m_ecnt = 0; m_wraps = 0;
        m_ref_ok = 0; m_prev_ok = 0; m_ref = 0; m_prev = 4'd0;
        m_locked = 0; m_pulse = 0; m_fp = 0; m_fs = 0; m_ft = 0;
    endtask

    task automatic model_step(input logic [3:0] p, input logic [15:0] q, input logic tc,
                              input logic e, input logic clr, input logic rst);
        bit ep, es, et, any, strobe, onehot, had_ref;
        logic [3:0] rot;
        if (rst) begin
            model_reset();
            return;
        end
        ep = 0; es = 0; et = 0; strobe = 0;
        onehot  = ($countones(p) == 1);
        rot     = {m_prev[2:0], m_prev[3]};
        had_ref = m_ref_ok;
        if (e && m_mode != 0) begin
            ep = !onehot || (m_prev_ok && p != rot);
            strobe = p[3] && !ep;
            if (strobe) begin
                es = m_ref_ok && (int'(q) != (m_ref + 1) % 65536);
                et = (tc == 1'b1) != (q == 16'hFFFF);
            end
        end
        any = ep || es || et;
        if (any) begin
            if (clr) begin
                m_fp = ep; m_fs = es; m_ft = et; m_ecnt = 1;
            end else begin
                m_fp |= ep; m_fs |= es; m_ft |= et;
                m_ecnt = (m_ecnt < CMAX) ? m_ecnt + 1 : CMAX;
            end
        end else if (clr) begin
            m_fp = 0; m_fs = 0; m_ft = 0; m_ecnt = 0;
        end
        if (strobe && !any && q == 16'hFFFF && m_wraps < CMAX) m_wraps++;

        if (!e) begin
            m_mode = 0; m_ref_ok = 0; m_prev_ok = 0; m_good = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else begin
            m_prev = p; m_prev_ok = onehot;
            if (strobe) begin m_ref = int'(q); m_ref_ok = 1; end
            if (any) begin
                m_mode = 1; m_good = 0;
            end else if (strobe && had_ref && m_mode == 1) begin
                m_good++;
                if (m_good == ACQ_GOOD) begin m_mode = 2; m_good = 0; end
            end
        end
        m_locked = (m_mode == 2);
        m_pulse  = any;
    endtask

    // one clock: drive at negedge, advance model, compare after the edge
    task automatic cyc(input logic [3:0] p, input logic [15:0] q, input logic tc,
                       input logic e, input logic clr, input logic rst);
        @(negedge clk);
        {sQ3, sQ2, sQ1, sQ0} = p;
        Q = q; TC = tc; en = e; clr_err = clr; reset = rst;
        model_step(p, q, tc, e, clr, rst);
        @(posedge clk);
        #1;
        check("locked",    32'(locked),    32'(m_locked));
        check("err_pulse", 32'(err_pulse), 32'(m_pulse));
        check("err_phase", 32'(err_phase), 32'(m_fp));
        check("err_seq",   32'(err_seq),   32'(m_fs));
        check("err_tc",    32'(err_tc),    32'(m_ft));
        check("err_cnt",   32'(err_cnt),   32'(m_ecnt));
        check("wraps",     32'(wraps),     32'(m_wraps));
    endtask

    // one well-formed cycle of the counter; optional clear and TC corruption
    task automatic step1(input logic clr, input logic tcflip);
        logic [3:0]  p;
        logic [15:0] q;
        logic        tc;
        p  = 4'b0001 << k;
        q  = (k == 3) ? cnt : 16'($urandom);
        tc = (k == 3) ? ((q == 16'hFFFF) ^ tcflip) : 1'($urandom);
        cyc(p, q, tc, 1'b1, clr, 1'b0);
        if (k == 3) cnt++;
        k = (k + 1) % 4;
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) step1(1'b0, 1'b0);
    endtask

    task automatic align(input int want);
        for (int i = 0; i < 4 && k != want; i++) step1(1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        k = 0; cnt = 16'd0;
        cyc(4'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(4'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);

        // clean run from 0: one reference strobe plus four good ones
        k = 0;
        clean(1);
        k = 0;
        for (int s = 0; s < 5; s++) begin
            clean(4);
            check("lock_rise", 32'(locked), (s == 4) ? 32'd1 : 32'd0);
        end
        check("clean_err_cnt", 32'(err_cnt), 32'd0);

        // en low with garbage phases: no errors, drops to idle
        for (int i = 0; i < 8; i++) cyc(4'($urandom), 16'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0);
        check("en_off_locked", 32'(locked), 32'd0);
        check("en_off_err_cnt", 32'(err_cnt), 32'd0);

        // relock near the top and wrap through FFFF -> 0000
        cnt = 16'hFFF8; k = 0;
        clean(1); k = 0;
        clean(48);
        check("wrap_wraps", 32'(wraps), 32'd1);
        check("wrap_locked", 32'(locked), 32'd1);
        check("wrap_err_cnt", 32'(err_cnt), 32'd0);

        // count skip while locked
        align(3);
        cnt++;
        step1(1'b0, 1'b0);
        check("skip_seq", 32'(err_seq), 32'd1);
        check("skip_cnt", 32'(err_cnt), 32'd1);
        check("skip_locked", 32'(locked), 32'd0);
        clean(16);
        check("skip_relock", 32'(locked), 32'd1);
        step1(1'b1, 1'b0);

        // non-one-hot phase while locked
        align(1);
        cyc(4'b0011, 16'($urandom), 1'b0, 1'b1, 1'b0, 1'b0);
        k = 2;
        check("phase_flag", 32'(err_phase), 32'd1);
        check("phase_cnt", 32'(err_cnt), 32'd1);
        check("phase_locked", 32'(locked), 32'd0);
        clean(16);
        step1(1'b1, 1'b0);

        // bad phase with sQ3 and a TC mismatch: only the phase class fires
        align(3);
        cyc(4'b1001, cnt, (cnt != 16'hFFFF), 1'b1, 1'b0, 1'b0);
        k = 0;
        check("combo_cnt", 32'(err_cnt), 32'd1);
        check("combo_phase", 32'(err_phase), 32'd1);
        check("combo_tc", 32'(err_tc), 32'd0);
        clean(16);
        step1(1'b1, 1'b0);

        // TC mismatch then clear
        align(3);
        step1(1'b0, 1'b1);
        check("tc_flag", 32'(err_tc), 32'd1);
        step1(1'b1, 1'b0);
        check("clr_tc", 32'(err_tc), 32'd0);
        check("clr_cnt", 32'(err_cnt), 32'd0);
        check("clr_wraps", 32'(wraps), 32'd1);
        clean(16);
        check("tc_relock", 32'(locked), 32'd1);

        // reset while locked
        cyc(4'b0001, 16'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("midrst_locked", 32'(locked), 32'd0);
        check("midrst_wraps", 32'(wraps), 32'd0);

        // err_cnt saturation
        clean(2);
        for (int i = 0; i < CMAX + 40; i++) cyc(4'b0011, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("sat_cnt", 32'(err_cnt), 32'(CMAX));
        cyc(4'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        // randomized fault injection
        k = 0; cnt = 16'($urandom);
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 3) begin
                cyc(4'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            end else if (r < 13) begin
                cyc(4'($urandom), 16'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'b0);
            end else if (r < 33) begin
                cyc(4'($urandom), 16'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0);
                k = (k + 1) % 4;
            end else if (r < 53) begin
                cnt = cnt + 16'($urandom_range(1, 3));
                step1(1'b0, 1'b0);
            end else if (r < 73) begin
                step1(1'b0, 1'b1);
            end else if (r < 83) begin
                step1(1'b1, 1'($urandom));
            end else begin
                step1(1'b0, 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
